pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (e.g. nextpc plus instruction).
REQ-002 SHALL have parameter NOP, default 0 (WIDTH bits), value driven on out_data whenever out_valid is 0.
REQ-003 SHALL have parameter CNT_W, default 8, width of the flush counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port flush, input, 1, discards all stored and incoming beats.
REQ-007 SHALL have port in_valid, input, 1, upstream beat present.
REQ-008 SHALL have port in_ready, output, 1, stage can accept a beat.
REQ-009 SHALL have port in_data, input, WIDTH, upstream payload.
REQ-010 SHALL have port out_valid, output, 1, downstream beat present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the beat.
REQ-012 SHALL have port out_data, output, WIDTH, downstream payload.
REQ-013 SHALL have port occupancy, output, 2, number of stored beats (0..2).
REQ-014 SHALL have port flush_cnt, output, CNT_W, saturating count of beats discarded by flush.

Function
REQ-015 Transfers SHALL occur on a rising edge where valid and ready are both 1 on the same side; accept = in_valid & in_ready, pop = out_valid & out_ready.
REQ-016 Latency SHALL be 1 cycle: a beat accepted at edge N appears on out_data after edge N when the stage was empty.
REQ-017 Beats SHALL leave in acceptance order; none are duplicated or dropped except by flush.
REQ-018 State machine SHALL have states EMPTY, ONE and TWO; occupancy SHALL equal 0, 1 and 2 respectively.
REQ-019 EMPTY: accept -> ONE, payload into main register; otherwise stay.
REQ-020 ONE: accept & !pop -> TWO, payload into skid register; accept & pop -> ONE, main <= in_data; pop & !accept -> EMPTY; neither -> stay.
REQ-021 TWO: pop -> ONE, main <= skid; no accept is possible because in_ready is 0.
REQ-022 out_valid SHALL be 1 in ONE and TWO; out_data SHALL equal main when out_valid is 1, otherwise NOP.
REQ-023 in_ready SHALL be a registered output equal to 1 unless the next state is TWO.
REQ-024 If flush is 1, next state SHALL be EMPTY regardless of accept or pop; a beat accepted in the same cycle SHALL be discarded.
REQ-025 On flush, flush_cnt SHALL increase by the number of stored beats (0, 1 or 2) and saturate at 2^CNT_W-1 with no wrap-around.
REQ-026 The incoming beat discarded with flush SHALL NOT be counted.
REQ-027 out_valid, in_ready and out_data SHALL be glitch-free register outputs, apart from the NOP mux selected by registered state.

Reset
REQ-028 While rst is 0 at an edge: state EMPTY, occupancy 0, out_valid 0, out_data NOP, in_ready 1, flush_cnt 0; main and skid registers reset to NOP.
REQ-029 Reset SHALL take priority over flush, accept and pop, including mid-transfer with the stage in TWO.
REQ-030 The first edge with rst at 1 SHALL be able to accept a beat.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined: full two-entry behaviour of REQ-018..REQ-023.
REQ-032 Macro PIPE_STAGE_SKID_EN undefined:
- no skid register and no TWO state; occupancy is at most 1.
- in_ready is combinational: out_ready | ~out_valid.
- ONE with accept & pop -> ONE; ONE with accept & !pop is impossible.
- flush counts at most 1 beat per flush; all other requirements unchanged.

Verification
REQ-033 Reset then stream: in_valid=1 with 0x11,0x22,0x33 on consecutive cycles and out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each; occupancy stays 1.
REQ-034 Backpressure (SKID_EN): hold out_ready=0 and offer 0xA1,0xA2,0xA3 -> 0xA1 and 0xA2 stored, occupancy 2, in_ready 0, 0xA3 held upstream; release out_ready -> order 0xA1,0xA2,0xA3.
REQ-035 Flush in TWO with in_valid=1 -> next cycle out_valid 0, out_data NOP, occupancy 0, in_ready 1, flush_cnt +2.
REQ-036 Saturation (CNT_W=2): six flushes, each with the stage in ONE -> flush_cnt reaches 3 and holds at 3.
REQ-037 rst=0 asserted while in TWO with flush=1 -> all outputs at reset values and flush_cnt 0 at the next edge.
REQ-038 SKID_EN undefined: out_ready=0 with the stage in ONE -> in_ready 0 in the same cycle; out_ready=1 -> simultaneous pop and accept.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Valid/ready pipeline register with one-cycle latency. With the skid
//   entry enabled the stage holds up to two beats so in_ready can come
//   straight from a flop; without it the stage holds one beat and in_ready
//   is derived combinationally from out_ready.
//
// Configuration macro:
//   PIPE_STAGE_SKID_EN  defined   -> two-entry stage (EMPTY/ONE/TWO), registered in_ready
//                       undefined -> single-entry stage (EMPTY/ONE), in_ready = out_ready | ~out_valid
//
// Parameters:
//   WIDTH  payload width in bits
//   NOP    value presented on out_data while out_valid is 0
//   CNT_W  width of the saturating flush counter
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-low reset
//   flush      discard all stored beats and any beat offered this cycle
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat
//   in_data    upstream payload
//   out_valid  downstream beat present
//   out_ready  downstream accepts the beat
//   out_data   downstream payload (NOP when out_valid is 0)
//   occupancy  number of stored beats
//   flush_cnt  saturating count of stored beats discarded by flush

module pipe_stage_reg #(
  parameter int unsigned           WIDTH = 32,
  parameter logic [WIDTH-1:0]      NOP   = '0,
  parameter int unsigned           CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_cnt
);

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               accept;
  logic               pop;
  logic [1:0]         stored;
  logic [CNT_W:0]     cnt_sum;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    flush_cnt_d = flush_cnt_q;
    stored      = 2'd0;
    cnt_sum     = '0;

    accept = in_valid & in_ready_q;
    pop    = out_valid_q & out_ready;

    case (state_q)
      EMPTY: begin
        stored = 2'd0;
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        stored = 2'd1;
        if (accept && !pop) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (accept && pop) begin
          main_d  = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        stored = 2'd2;
        // in_ready_q is 0 here, so only a pop can happen
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        stored  = 2'd0;
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      // The beat offered alongside flush is dropped and not counted
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_sum = {1'b0, flush_cnt_q} + (CNT_W+1)'(stored);
      flush_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Registered handshake outputs follow the state being entered
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= NOP;
      skid_q      <= NOP;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? main_q : NOP;
  assign flush_cnt = flush_cnt_q;

`else

  typedef enum logic {
    EMPTY = 1'b0,
    ONE   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               in_ready_c;
  logic               accept;
  logic               pop;
  logic [1:0]         stored;
  logic [CNT_W:0]     cnt_sum;

  // Without a skid entry the stage can only take a beat when it is empty
  // or the held beat leaves in the same cycle.
  assign in_ready_c = out_ready | ~out_valid_q;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    flush_cnt_d = flush_cnt_q;
    stored      = 2'd0;
    cnt_sum     = '0;

    accept = in_valid & in_ready_c;
    pop    = out_valid_q & out_ready;

    case (state_q)
      EMPTY: begin
        stored = 2'd0;
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        stored = 2'd1;
        // accept without pop cannot occur: in_ready_c is 0 then
        if (accept) begin
          main_d  = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      default: begin
        stored  = 2'd0;
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      cnt_sum = {1'b0, flush_cnt_q} + (CNT_W+1)'(stored);
      flush_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= NOP;
      out_valid_q <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      out_valid_q <= out_valid_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign occupancy = {1'b0, (state_q == ONE)};
  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? main_q : NOP;
  assign flush_cnt = flush_cnt_q;

`endif

endmodule
